// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.
// Words are taken with a valid/ready handshake, and the serial line is driven from a register.
module uart_tx_cfg #(
  parameter int UART_BPS  = 'd9600,
  parameter int CLK_FREQ  = 'd50_000_000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 pi_valid,
  input  logic [DATA_BITS-1:0] pi_data,
  output logic                 pi_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int BAUD_W       = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam int BIT_W        = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (BAUD_CNT_MAX < 1) begin : g_bad_baud
      $error("uart_tx_cfg: CLK_FREQ must be at least UART_BPS");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;
  logic                   baud_end;

  assign baud_end = (baud_cnt_q == BAUD_LAST);
  assign pi_ready = (state_q == S_IDLE);
  assign tx_busy  = (state_q != S_IDLE);
  assign tx       = tx_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    if (state_q != S_IDLE) begin
      baud_cnt_d = baud_end ? '0 : baud_cnt_q + BAUD_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (pi_valid) begin
          state_d = S_START;
          shift_d = pi_data;
        end
      end
      S_START: begin
        // The latched word is intact here, before any shifting starts.
        parity_d = ^shift_q;
        if (baud_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = (PARITY != 0) ? S_PAR : S_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      S_PAR: begin
        if (baud_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line level follows the next state so the first start-bit clock directly follows acceptance.
  always_comb begin
    tx_d    = 1'b1;
    tx_done = (state_q == S_STOP) && baud_end && (bit_cnt_q == STOP_LAST);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = (PARITY == 2) ? parity_q : ~parity_q;
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four differently configured instances at 10 clocks per bit,
// each checked against bit sequences rebuilt from the frame format.
module tb_uart_tx_cfg;

  localparam int CLKF     = 1_000_000;
  localparam int BPS      = 100_000;
  localparam int BIT_CLKS = CLKF / BPS;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] vld   = 4'b0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic [6:0] d3 = '0;
  logic [3:0] rdy, txl, busy, done;

  int total = 0;
  int bad   = 0;
  int done_cnt [4] = '{0, 0, 0, 0};
  int nbits    [4] = '{8, 8, 8, 7};
  int par_mode [4] = '{0, 1, 2, 0};
  int nstops   [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_cfg #(.UART_BPS(BPS), .CLK_FREQ(CLKF), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi_valid(vld[0]), .pi_data(d0),
    .pi_ready(rdy[0]), .tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_cfg #(.UART_BPS(BPS), .CLK_FREQ(CLKF), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi_valid(vld[1]), .pi_data(d1),
    .pi_ready(rdy[1]), .tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_cfg #(.UART_BPS(BPS), .CLK_FREQ(CLKF), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi_valid(vld[2]), .pi_data(d2),
    .pi_ready(rdy[2]), .tx(txl[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_cfg #(.UART_BPS(BPS), .CLK_FREQ(CLKF), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi_valid(vld[3]), .pi_data(d3),
    .pi_ready(rdy[3]), .tx(txl[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) done_cnt[i] += int'(done[i]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int inst, input logic [8:0] v);
    case (inst)
      0: d0 = v[7:0];
      1: d1 = v[7:0];
      2: d2 = v[7:0];
      default: d3 = v[6:0];
    endcase
  endtask

  task automatic check_idle(input int inst, input string what);
    check($sformatf("%s u%0d tx", what, inst), 32'(txl[inst]), 32'd1);
    check($sformatf("%s u%0d ready", what, inst), 32'(rdy[inst]), 32'd1);
    check($sformatf("%s u%0d busy", what, inst), 32'(busy[inst]), 32'd0);
    check($sformatf("%s u%0d done", what, inst), 32'(done[inst]), 32'd0);
  endtask

  // Called just after the accept edge; checks every clock of the frame on the falling edge.
  task automatic run_frame(input int inst, input logic [8:0] d, input int poke_cycle,
                           input int abort_cycle);
    bit q[$];
    int ones = 0;
    int ncyc;
    q.push_back(1'b0);
    for (int i = 0; i < nbits[inst]; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par_mode[inst] == 1) q.push_back((ones % 2) == 0);
    else if (par_mode[inst] == 2) q.push_back((ones % 2) == 1);
    for (int i = 0; i < nstops[inst]; i++) q.push_back(1'b1);
    ncyc = q.size() * BIT_CLKS;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      check($sformatf("u%0d tx clk%0d", inst, c), 32'(txl[inst]), 32'(q[(c - 1) / BIT_CLKS]));
      check($sformatf("u%0d ready clk%0d", inst, c), 32'(rdy[inst]), 32'd0);
      check($sformatf("u%0d busy clk%0d", inst, c), 32'(busy[inst]), 32'd1);
      check($sformatf("u%0d done clk%0d", inst, c), 32'(done[inst]), 32'(c == ncyc));
      if (poke_cycle > 0 && c == poke_cycle) begin
        set_data(inst, ~d);
        vld[inst] = 1'b1;
      end
      if (poke_cycle > 0 && c == poke_cycle + 1) vld[inst] = 1'b0;
      if (abort_cycle > 0 && c == abort_cycle) begin
        rst_n = 1'b0;
        #1;
        check_idle(inst, "async reset");
        $display("u%0d frame data=%0h abandoned by reset at clock %0d", inst, d, c);
        return;
      end
    end
    $display("u%0d frame data=%0h bits=%0d clocks=%0d", inst, d, q.size(), ncyc);
  endtask

  task automatic send(input int inst, input logic [8:0] d, input int poke_cycle,
                      input int abort_cycle);
    int base = done_cnt[inst];
    set_data(inst, d);
    vld[inst] = 1'b1;
    @(posedge clk);
    #1 vld[inst] = 1'b0;
    run_frame(inst, d, poke_cycle, abort_cycle);
    if (abort_cycle == 0) begin
      @(negedge clk);
      check_idle(inst, "post-frame");
      check($sformatf("u%0d done pulses", inst), 32'(done_cnt[inst] - base), 32'd1);
    end
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) check_idle(i, "in reset");
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) check_idle(i, "after reset");

    send(0, 9'h055, 0, 0);
    send(2, 9'h007, 0, 0);
    send(1, 9'h007, 0, 0);
    send(2, 9'h000, 0, 0);
    send(3, 9'h07F, 0, 0);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        send(i, 9'($urandom_range(0, (1 << nbits[i]) - 1)), 0, 0);
      end
    end

    // Back-to-back with valid held high.
    base = done_cnt[0];
    set_data(0, 9'h0A5);
    vld[0] = 1'b1;
    @(posedge clk);
    #1 set_data(0, 9'h03C);
    run_frame(0, 9'h0A5, 0, 0);
    @(negedge clk);
    check("b2b gap tx", 32'(txl[0]), 32'd1);
    check("b2b gap ready", 32'(rdy[0]), 32'd1);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    run_frame(0, 9'h03C, 0, 0);
    @(negedge clk);
    check_idle(0, "b2b end");
    check("b2b done pulses", 32'(done_cnt[0] - base), 32'd2);

    // Request while busy must be ignored.
    base = done_cnt[0];
    send(0, 9'h096, 35, 0);
    repeat (20) begin
      @(negedge clk);
      check("busy poke no new frame tx", 32'(txl[0]), 32'd1);
      check("busy poke no new frame busy", 32'(busy[0]), 32'd0);
    end
    check("busy poke done pulses", 32'(done_cnt[0] - base), 32'd1);

    // Reset during data bit 3, then a clean frame.
    base = done_cnt[0];
    send(0, 9'($urandom_range(0, 255)), 0, 45);
    repeat (3) begin
      @(negedge clk);
      check_idle(0, "held reset");
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "reset released");
    check("reset no done", 32'(done_cnt[0] - base), 32'd0);
    send(0, 9'h081, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART serial transmitter, successor to the fixed 8N1 transmitter in rs232_serial. It adds configurable data width, optional odd/even parity and one or two stop bits. Input data is captured with a valid/ready handshake, so the source may change pi_data once its byte has been accepted. It feeds a board TX pin, or a loopback/test harness, directly from a byte source such as a FIFO or a command sequencer.

Parameters:
UART_BPS, 'd9600, baud rate in bit/s.
CLK_FREQ, 'd50_000_000, sys_clk frequency in Hz.
DATA_BITS, 8, payload bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even. Any other value is an elaboration error.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
sys_clk  input  1  system clock, rising edge.
sys_rst_n  input  1  asynchronous active-low reset.
pi_valid  input  1  source has a word to send.
pi_data  input  DATA_BITS  word to send, transmitted LSB first.
pi_ready  output  1  transmitter can accept a word; high only in IDLE.
tx  output  1  serial line, registered, idles high.
tx_busy  output  1  high while a frame is in progress (not IDLE).
tx_done  output  1  one-cycle pulse marking the end of a frame.

Behaviour:
- One clock (sys_clk); reset is asynchronous and active-low (sys_rst_n). All state resets asynchronously.
- Reset values: tx=1, pi_ready=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0.
- BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division). Baud counter width = $clog2(BAUD_CNT_MAX).
- Every bit period is exactly BAUD_CNT_MAX clocks. The baud counter runs 0..BAUD_CNT_MAX-1, wraps at the end of each bit, and is held at 0 in IDLE.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - pi_ready = 1, tx = 1.
  - A word is accepted on the clock edge where pi_valid && pi_ready. pi_data is latched into a shift register and parity is computed from the latched value.
  - The state then moves to START.
- START: tx = 0 for one bit period. The first start-bit clock is the cycle immediately after the accept edge (one-cycle latency).
- DATA:
  - DATA_BITS bit periods, LSB first, taken from the latched copy.
  - A bit counter counts 0..DATA_BITS-1.
  - After the last data bit, the state moves to PAR if PARITY != 0, otherwise to STOP.
- PAR: one bit period.
  - Even parity: tx = XOR of the data bits.
  - Odd parity: tx = inverted XOR of the data bits.
- STOP: tx = 1 for STOP_BITS bit periods.
  - tx_done is asserted during the final clock of the last stop bit; on the next edge the state returns to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_CNT_MAX clocks, measured from the first start-bit clock.
- Back-to-back operation: with pi_valid held high, the next word is accepted in the first IDLE cycle. The inter-frame gap is therefore exactly 1 clock of tx=1 beyond the stop bits.
- pi_valid while busy: pi_ready is 0, so the request is not accepted and nothing is latched. pi_data changes after acceptance have no effect on the current frame.
- Reset mid-frame: tx goes to 1 immediately (asynchronously), the frame is abandoned and no tx_done is generated. pi_ready is 1 after reset is released.
- tx_busy = (state != IDLE). pi_ready = (state == IDLE). Both are decoded from registered state and are glitch-free.

Test Plan:
- Use CLK_FREQ=1_000_000 and UART_BPS=100_000 (10 clocks per bit) for every scenario.
- 8N1, accept 0x55 -> tx bit sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly 10 clocks; tx_done pulses once, on the 100th clock after accept; pi_ready is low for 100 clocks.
- PARITY=2, send 0x07 -> parity bit 1; PARITY=1, send 0x07 -> parity bit 0; PARITY=2, send 0x00 -> parity bit 0. Frame is 110 clocks in each case.
- DATA_BITS=7, STOP_BITS=2, send 0x7F -> start 0, seven 1 data bits, then 20 clocks of stop high; tx_done at clock 100.
- pi_valid held high with 0xA5 then 0x3C (8N1) -> two correct frames separated by exactly 1 idle clock; 2 tx_done pulses total.
- While busy, change pi_data and pulse pi_valid -> current frame is unchanged and no extra frame is sent.
- Assert sys_rst_n low during data bit 3 -> tx=1 in the same cycle, no tx_done; after release, send 0x81 -> a correct frame is sent.
